// File: rtl/wbm_arb_pkg.sv
// Shared types and helpers for the wishbone master arbiter.
// Holds the one-hot FSM encoding and width helpers.
package wbm_arb_pkg;

   localparam int I_IDLE  = 0;
   localparam int I_ISSUE = 1;
   localparam int I_ACK   = 2;
   localparam int I_RUN   = 3;
   localparam int I_DONE  = 4;

   typedef enum logic [4:0] {
      S_IDLE  = 5'b00001,
      S_ISSUE = 5'b00010,
      S_ACK   = 5'b00100,
      S_RUN   = 5'b01000,
      S_DONE  = 5'b10000
   } state_t;

   localparam int ACK_WAIT_DEF = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/wbm_rr_pick.sv
// Winner selection for the arbiter: round-robin after ptr, or fixed
// priority (lowest index) when WBM_ARBITER_FIXED_PRIO_EN is defined.
module wbm_rr_pick
   import wbm_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   assign any = |req;

`ifdef WBM_ARBITER_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            idx    = IW'(i);
         end
      end
   end
`else
   // Walk from farthest to nearest so ptr+1 is the last (winning) hit.
   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      for (int i = N; i >= 1; i--) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end
`endif

endmodule

// File: rtl/wbm_arbiter.sv
// Shares one wishbone master engine among NUM_REQ requesters.
// Define WBM_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority.
module wbm_arbiter
   import wbm_arb_pkg::*;
#(
   parameter  int NUM_REQ       = 4,
   parameter  int ADDRESS_WIDTH = 16,
   parameter  int DATA_WIDTH    = 8,
   parameter  int MAX_PAYLOAD   = 8,
   parameter  int LEN_W         = 4,
   parameter  int ACK_WAIT      = ACK_WAIT_DEF,
   localparam int PAYLOAD_W     = MAX_PAYLOAD * DATA_WIDTH,
   localparam int IDX_W         = idx_w(NUM_REQ)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ-1:0]           req_we_i,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_adr_i,
   input  logic [NUM_REQ*LEN_W-1:0]     req_len_i,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] req_dat_i,
   output logic [NUM_REQ-1:0]           gnt_o,
   output logic [NUM_REQ-1:0]           done_o,
   output logic [NUM_REQ-1:0]           err_o,
   output logic [PAYLOAD_W-1:0]         rdata_o,
   output logic [ADDRESS_WIDTH-1:0]     m_adr_o,
   output logic [PAYLOAD_W-1:0]         m_dat_o,
   output logic [LEN_W-1:0]             m_len_o,
   output logic                         m_start_read_o,
   output logic                         m_start_write_o,
   input  logic [PAYLOAD_W-1:0]         m_dat_i,
   input  logic                         m_read_busy_i,
   input  logic                         m_write_busy_i,
   input  logic                         m_completed_i,
   input  logic                         m_timeout_i
);

   // ACK spans the start cycle plus the engine's register delay.
   localparam int CNT_W = clog2(ACK_WAIT + 2);
   localparam logic [CNT_W-1:0] ACK_LIM = CNT_W'(ACK_WAIT + 1);

   state_t state_q, state_d;

   logic [NUM_REQ-1:0]       gnt_q;
   logic [IDX_W-1:0]         ptr_q, idx_q;
   logic                     we_q, err_q, start_q;
   logic [ADDRESS_WIDTH-1:0] adr_q;
   logic [LEN_W-1:0]         len_q;
   logic [PAYLOAD_W-1:0]     dat_q, rdata_q;
   logic [CNT_W-1:0]         cnt_q;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               busy;

   assign busy = m_read_busy_i | m_write_busy_i;

   wbm_rr_pick #(
      .N  (NUM_REQ),
      .IW (IDX_W)
   ) u_pick (
      .req (req_i),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         state_q[I_IDLE]:  if (pick_any) state_d = S_ISSUE;
         state_q[I_ISSUE]: state_d = S_ACK;
         state_q[I_ACK]: begin
            if (busy)                 state_d = S_RUN;
            else if (cnt_q == ACK_LIM) state_d = S_DONE;
         end
         state_q[I_RUN]:   if (!busy) state_d = S_DONE;
         state_q[I_DONE]:  state_d = S_IDLE;
         default:          state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gnt_q   <= '0;
         ptr_q   <= '0;
         idx_q   <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         adr_q   <= '0;
         len_q   <= '0;
         dat_q   <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         start_q <= 1'b0;
         unique case (1'b1)
            state_q[I_IDLE]: if (pick_any) begin
               gnt_q <= pick_gnt;
               idx_q <= pick_idx;
               err_q <= 1'b0;
               we_q  <= req_we_i[pick_idx];
               adr_q <= req_adr_i[pick_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
               len_q <= req_len_i[pick_idx*LEN_W +: LEN_W];
               dat_q <= req_dat_i[pick_idx*PAYLOAD_W +: PAYLOAD_W];
            end
            state_q[I_ISSUE]: begin
               start_q <= 1'b1;
               cnt_q   <= '0;
            end
            state_q[I_ACK]: if (!busy) begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == ACK_LIM) err_q <= 1'b1;
            end
            state_q[I_RUN]: if (!busy) begin
               err_q <= m_timeout_i | ~m_completed_i;
               if (!we_q) rdata_q <= m_dat_i;
            end
            state_q[I_DONE]: begin
               ptr_q <= idx_q;
               gnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign gnt_o           = gnt_q;
   assign done_o          = state_q[I_DONE] ? gnt_q : '0;
   assign err_o           = (state_q[I_DONE] & err_q) ? gnt_q : '0;
   assign rdata_o         = rdata_q;
   assign m_adr_o         = adr_q;
   assign m_dat_o         = dat_q;
   assign m_len_o         = len_q;
   assign m_start_read_o  = start_q & ~we_q;
   assign m_start_write_o = start_q & we_q;

endmodule

// File: tb/tb_wbm_arbiter.sv
// Scoreboard bench for wbm_arbiter with a behavioural engine model.
// Directed transactions; a negedge monitor checks every done_o pulse.
module tb_wbm_arbiter;

   localparam int N   = 4;
   localparam int AW  = 16;
   localparam int LW  = 4;
   localparam int PW  = 64;
   localparam int AKW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req, req_we;
   logic [N*AW-1:0] req_adr;
   logic [N*LW-1:0] req_len;
   logic [N*PW-1:0] req_dat;
   logic [N-1:0]  gnt_o, done_o, err_o;
   logic [PW-1:0] rdata_o, m_dat_o, m_dat_i;
   logic [AW-1:0] m_adr_o;
   logic [LW-1:0] m_len_o;
   logic          m_start_read_o, m_start_write_o;
   logic          m_read_busy_i, m_write_busy_i;
   logic          m_completed_i, m_timeout_i;

   wbm_arbiter dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_i           (req),
      .req_we_i        (req_we),
      .req_adr_i       (req_adr),
      .req_len_i       (req_len),
      .req_dat_i       (req_dat),
      .gnt_o           (gnt_o),
      .done_o          (done_o),
      .err_o           (err_o),
      .rdata_o         (rdata_o),
      .m_adr_o         (m_adr_o),
      .m_dat_o         (m_dat_o),
      .m_len_o         (m_len_o),
      .m_start_read_o  (m_start_read_o),
      .m_start_write_o (m_start_write_o),
      .m_dat_i         (m_dat_i),
      .m_read_busy_i   (m_read_busy_i),
      .m_write_busy_i  (m_write_busy_i),
      .m_completed_i   (m_completed_i),
      .m_timeout_i     (m_timeout_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req_v);
      tests++;
      if (act !== req_v) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req_v);
      end
   endtask

   // Engine model: mode 0 normal, 1 timeout, 2 dead (never busy).
   logic [7:0] mem [0:1023];
   int         eng_mode = 0;
   int         eng_len  = 2;
   logic       e_busy, e_we, comp, tout;
   int         e_cnt;
   logic [PW-1:0] e_rd, edat;
   int         st_rd = 0, st_wr = 0, st_cyc = 0;
   logic [AW-1:0] st_adr;
   logic [LW-1:0] st_len;
   logic [PW-1:0] st_dat;

   function automatic logic [63:0] gather(input logic [15:0] a,
                                          input logic [3:0] l);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         if (i < int'(l)) r[i*8 +: 8] = mem[(int'(a) + i) % 1024];
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_busy <= 1'b0;
         e_we   <= 1'b0;
         comp   <= 1'b0;
         tout   <= 1'b0;
         edat   <= '0;
         e_cnt  <= 0;
      end else if (m_start_read_o || m_start_write_o) begin
         if (m_start_read_o)  st_rd <= st_rd + 1;
         if (m_start_write_o) st_wr <= st_wr + 1;
         st_cyc <= cyc;
         st_adr <= m_adr_o;
         st_len <= m_len_o;
         st_dat <= m_dat_o;
         if (eng_mode != 2) begin
            e_busy <= 1'b1;
            e_cnt  <= eng_len;
            e_we   <= m_start_write_o;
            comp   <= 1'b0;
            tout   <= 1'b0;
            e_rd   <= gather(m_adr_o, m_len_o);
         end
      end else if (e_busy) begin
         if (e_cnt <= 1) begin
            e_busy <= 1'b0;
            comp   <= (eng_mode == 0);
            tout   <= (eng_mode == 1);
            if (!e_we && eng_mode == 0) edat <= e_rd;
         end else begin
            e_cnt <= e_cnt - 1;
         end
      end
   end

   assign m_read_busy_i  = e_busy & ~e_we;
   assign m_write_busy_i = e_busy & e_we;
   assign m_completed_i  = comp;
   assign m_timeout_i    = tout;
   assign m_dat_i        = edat;

   typedef struct {
      logic [N-1:0]  done;
      logic [N-1:0]  err;
      logic [PW-1:0] rdata;
   } exp_t;

   exp_t exp_q[$];

   task automatic push_exp(input logic [N-1:0] d, input logic [N-1:0] e,
                           input logic [PW-1:0] r);
      exp_t x;
      x.done  = d;
      x.err   = e;
      x.rdata = r;
      exp_q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (!rst && done_o != '0) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done actual=%b required=none", done_o);
         end else begin
            exp_t x;
            x = exp_q.pop_front();
            chk("sb_done",  64'(done_o),  64'(x.done));
            chk("sb_err",   64'(err_o),   64'(x.err));
            chk("sb_gnt",   64'(gnt_o),   64'(x.done));
            chk("sb_rdata", rdata_o,      x.rdata);
         end
      end
   end

   task automatic set_req(input int k, input logic we, input logic [15:0] a,
                          input logic [3:0] l, input logic [63:0] d);
      req_we[k]           = we;
      req_adr[k*AW +: AW] = a;
      req_len[k*LW +: LW] = l;
      req_dat[k*PW +: PW] = d;
   endtask

   task automatic wait_done(output logic [N-1:0] d, output int at);
      d  = '0;
      at = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (done_o != '0) begin
            d  = done_o;
            at = cyc;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL wait_done actual=timeout required=done_pulse");
   endtask

   localparam logic [63:0] D_R0 = 64'h0000_0000_A4A3_A2A1;
   localparam logic [63:0] D_C0 = 64'h0000_0000_0000_2211;
   localparam logic [63:0] D_C1 = 64'h0000_0000_0000_0033;
   localparam logic [63:0] D_C2 = 64'h0807_0605_0403_0201;
   localparam logic [63:0] D_C3 = 64'h0000_0000_0066_5544;

   initial begin
      logic [N-1:0]  d;
      logic [N-1:0]  b2b_done [4];
      logic [63:0]   b2b_dat [4];
      logic [63:0]   last_rd;
      int            at, s0;
      bit            seen;

      rst = 1'b1;
      req = '0;
      req_we = '0;
      req_adr = '0;
      req_len = '0;
      req_dat = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[256] = 8'hA1; mem[257] = 8'hA2; mem[258] = 8'hA3; mem[259] = 8'hA4;
      mem[512] = 8'h11; mem[513] = 8'h22;
      mem[528] = 8'h33;
      for (int i = 0; i < 8; i++) mem[544 + i] = 8'(i + 1);
      mem[560] = 8'h44; mem[561] = 8'h55; mem[562] = 8'h66;

      repeat (2) @(negedge clk);
      chk("rst_gnt",   64'(gnt_o), 0);
      chk("rst_done",  64'(done_o), 0);
      chk("rst_err",   64'(err_o), 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_start", 64'({m_start_read_o, m_start_write_o}), 0);
      chk("rst_adr",   64'(m_adr_o), 0);
      chk("rst_len",   64'(m_len_o), 0);
      rst = 1'b0;
      @(negedge clk);

      // single read
      eng_mode = 0;
      eng_len  = 3;
      set_req(0, 1'b0, 16'h0100, 4'd4, 64'h0);
      push_exp(4'b0001, 4'b0000, D_R0);
      req[0] = 1'b1;
      wait_done(d, at);
      req = req & ~d;
      chk("rd_starts", 64'(st_rd), 1);
      chk("rd_wstarts", 64'(st_wr), 0);
      chk("rd_adr", 64'(st_adr), 64'h0100);
      chk("rd_len", 64'(st_len), 4);
      chk("rd_adr_hold", 64'(m_adr_o), 64'h0100);

      // engine timeout on a write from requester 3
      eng_mode = 1;
      eng_len  = 10;
      set_req(3, 1'b1, 16'h0300, 4'd8, 64'h1122_3344_5566_7788);
      push_exp(4'b1000, 4'b1000, D_R0);
      req[3] = 1'b1;
      wait_done(d, at);
      req = req & ~d;
      chk("wr_wstarts", 64'(st_wr), 1);
      chk("wr_dat", st_dat, 64'h1122_3344_5566_7788);

      // contention, every requester drops after its own done
      eng_mode = 0;
      eng_len  = 2;
      set_req(0, 1'b0, 16'h0200, 4'd2, 64'h0);
      set_req(1, 1'b0, 16'h0210, 4'd1, 64'h0);
      set_req(2, 1'b0, 16'h0220, 4'd8, 64'h0);
      set_req(3, 1'b0, 16'h0230, 4'd3, 64'h0);
      push_exp(4'b0001, 4'b0000, D_C0);
      push_exp(4'b0010, 4'b0000, D_C1);
      push_exp(4'b0100, 4'b0000, D_C2);
      push_exp(4'b1000, 4'b0000, D_C3);
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_done(d, at);
         req = req & ~d;
      end

      // back-to-back: req0 and req2 held
`ifdef WBM_ARBITER_FIXED_PRIO_EN
      b2b_done = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
      b2b_dat  = '{D_C0, D_C0, D_C0, D_C0};
`else
      b2b_done = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      b2b_dat  = '{D_C0, D_C2, D_C0, D_C2};
`endif
      for (int i = 0; i < 4; i++) push_exp(b2b_done[i], 4'b0000, b2b_dat[i]);
      req = 4'b0101;
      for (int i = 0; i < 4; i++) wait_done(d, at);
      req = '0;
      last_rd = b2b_dat[3];

      // dead engine: watchdog
      eng_mode = 2;
      s0 = st_rd + st_wr;
      push_exp(4'b0010, 4'b0010, last_rd);
      req[1] = 1'b1;
      wait_done(d, at);
      req = req & ~d;
      chk("dead_latency", 64'(at - st_cyc), 64'(AKW + 2));
      repeat (10) @(negedge clk);
      chk("dead_one_start", 64'(st_rd + st_wr - s0), 1);

      // reset during RUN
      eng_mode = 0;
      eng_len  = 20;
      set_req(2, 1'b1, 16'h0400, 4'd5, 64'hDEAD_BEEF_0BAD_F00D);
      push_exp(4'b0100, 4'b0000, 64'h0);
      req[2] = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         seen = m_write_busy_i;
      end
      chk("rr_busy_seen", 64'(seen), 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rr_gnt_clr", 64'(gnt_o), 0);
      chk("rr_start_clr", 64'({m_start_read_o, m_start_write_o}), 0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      push_exp(4'b0100, 4'b0000, 64'h0);
      @(posedge clk);
      #1;
      chk("rr_regrant", 64'(gnt_o), 64'b0100);
      wait_done(d, at);
      req = req & ~d;
      chk("rr_wdat", st_dat, 64'hDEAD_BEEF_0BAD_F00D);

      repeat (5) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
